// File: rtl/score_display_pkg.sv
// score_display_pkg: shared constants and FSM states for the score display controller
package score_display_pkg;
    localparam logic [3:0] BLANK_CODE = 4'hF;
    localparam int unsigned MAX_DISPLAY = 9999;
    typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;
endpackage

// File: rtl/blink_timer.sv
// blink_timer: free-running half-period counter; phase starts on and is held on while disabled
module blink_timer #(
    parameter int BLINK_DIV = 25_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic phase
);
    localparam int CW = $clog2(BLINK_DIV);
    logic [CW-1:0] cnt_q, cnt_d;
    logic phase_q, phase_d;
    logic wrap;
    assign wrap = cnt_q == CW'(BLINK_DIV - 1);
    always_comb begin
        cnt_d   = !en ? '0 : wrap ? '0 : cnt_q + CW'(1);
        phase_d = !en ? 1'b1 : wrap ? !phase_q : phase_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            phase_q <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end
    assign phase = phase_q;
endmodule

// File: rtl/score_display_ctrl.sv
// score_display_ctrl: binary-to-BCD conversion with leading-zero blanking, saturation and blink/blank mux
module score_display_ctrl
    import score_display_pkg::*;
#(
    parameter int BIN_W     = 14,
    parameter int DIGITS    = 4,
    parameter int BLINK_DIV = 25_000_000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [BIN_W-1:0]      value,
    input  logic                  blank_all,
    input  logic                  blink_en,
    output logic                  busy,
    output logic                  valid,
    output logic                  ovf,
    output logic [4*DIGITS-1:0]   digits
);
    localparam int CW = $clog2(BIN_W + 1);
    localparam int DW = 4 * DIGITS;
    state_t state_q, state_d;
    logic [BIN_W-1:0] bin_q, bin_d;
    logic [DW-1:0] bcd_q, bcd_d, dig_q, dig_d, adj, blanked;
    logic [CW-1:0] cnt_q, cnt_d;
    logic sat_q, sat_d, ovf_q, ovf_d, valid_q, valid_d;
    logic phase, lead;
    blink_timer #(.BLINK_DIV(BLINK_DIV)) u_blink (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (blink_en),
        .phase (phase)
    );
    // add-3 correction and leading-zero blanking; digit 0 is never blanked
    always_comb begin
        adj     = bcd_q;
        blanked = bcd_q;
        lead    = 1'b1;
        for (int i = 0; i < DIGITS; i++)
            adj[4*i+:4] = bcd_q[4*i+:4] >= 4'd5 ? bcd_q[4*i+:4] + 4'd3 : bcd_q[4*i+:4];
        for (int i = DIGITS - 1; i > 0; i--) begin
            if (lead && bcd_q[4*i+:4] == 4'd0) blanked[4*i+:4] = BLANK_CODE;
            else lead = 1'b0;
        end
    end
    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        dig_d   = dig_q;
        ovf_d   = ovf_q;
        valid_d = 1'b0;
        case (state_q)
            IDLE: if (load) begin
                bin_d   = value;
                bcd_d   = '0;
                cnt_d   = CW'(BIN_W);
                sat_d   = 32'(value) > MAX_DISPLAY;
                state_d = CONV;
            end
            CONV: begin
                {bcd_d, bin_d} = {adj, bin_q} << 1;
                cnt_d          = cnt_q - CW'(1);
                state_d        = cnt_q == CW'(1) ? COMMIT : CONV;
            end
            COMMIT: begin
                dig_d   = sat_q ? {DIGITS{4'd9}} : blanked;
                ovf_d   = sat_q;
                valid_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            dig_q   <= {DIGITS{BLANK_CODE}};
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
            dig_q   <= dig_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
        end
    end
    assign busy   = state_q != IDLE;
    assign valid  = valid_q;
    assign ovf    = ovf_q;
    assign digits = (blank_all || (blink_en && !phase)) ? {DIGITS{BLANK_CODE}} : dig_q;
endmodule

// File: tb/tb_score_display_ctrl.sv
// tb_score_display_ctrl: directed checks of conversion, blanking, saturation, reset abort and blink
module tb_score_display_ctrl;
    logic clk, rst_n, load, blank_all, blink_en;
    logic [13:0] value;
    logic busy, valid, ovf;
    logic [15:0] digits;
    int checks = 0;
    int errors = 0;
    int vcnt = 0;
    int v0;
    score_display_ctrl #(.BIN_W(14), .DIGITS(4), .BLINK_DIV(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .value     (value),
        .blank_all (blank_all),
        .blink_en  (blink_en),
        .busy      (busy),
        .valid     (valid),
        .ovf       (ovf),
        .digits    (digits)
    );
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end
    always @(negedge clk) if (valid === 1'b1) vcnt++;
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic pulse_load(input logic [13:0] v);
        load  = 1'b1;
        value = v;
        step();
        load  = 1'b0;
    endtask
    task automatic wait_done(input string tag, input int pre, input logic [15:0] exp_d, input logic exp_o);
        int n = pre;
        int v_start = vcnt;
        while (busy === 1'b1 && n < 40) begin
            n++;
            step();
        end
        chk({tag, "_busy_cycles"}, n, 15);
        chk({tag, "_valid"}, valid, 1);
        chk({tag, "_digits"}, digits, exp_d);
        chk({tag, "_ovf"}, ovf, exp_o);
        step();
        chk({tag, "_valid_drop"}, valid, 0);
        chk({tag, "_pulses"}, vcnt - v_start, 1);
    endtask
    initial begin
        rst_n = 1'b0; load = 1'b0; value = '0; blank_all = 1'b0; blink_en = 1'b0;
        step();
        step();
        chk("rst_digits", digits, 16'hFFFF);
        chk("rst_busy", busy, 0);
        chk("rst_valid", valid, 0);
        chk("rst_ovf", ovf, 0);
        rst_n = 1'b1;
        step();
        pulse_load(14'd1234);
        wait_done("v1234", 0, 16'h1234, 1'b0);
        pulse_load(14'd7);
        wait_done("v7", 0, 16'hFFF7, 1'b0);
        pulse_load(14'd0);
        wait_done("v0", 0, 16'hFFF0, 1'b0);
        pulse_load(14'd9999);
        wait_done("v9999", 0, 16'h9999, 1'b0);
        pulse_load(14'd1234);
        step();
        step();
        pulse_load(14'd5678);
        wait_done("ignored", 3, 16'h1234, 1'b0);
        repeat (20) step();
        chk("ignored_idle", busy, 0);
        chk("ignored_digits", digits, 16'h1234);
        pulse_load(14'd12000);
        wait_done("v12000", 0, 16'h9999, 1'b1);
        v0 = vcnt;
        pulse_load(14'd50);
        repeat (7) step();
        chk("mid_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_digits", digits, 16'hFFFF);
        chk("abort_busy", busy, 0);
        chk("abort_ovf", ovf, 0);
        chk("abort_valid", valid, 0);
        repeat (20) step();
        chk("abort_no_valid", vcnt - v0, 0);
        rst_n = 1'b1;
        step();
        chk("abort_digits_after", digits, 16'hFFFF);
        pulse_load(14'd50);
        wait_done("v50", 0, 16'hFF50, 1'b0);
        pulse_load(14'd42);
        wait_done("v42", 0, 16'hFF42, 1'b0);
        pulse_load(14'd1234);
        wait_done("blinkprep", 0, 16'h1234, 1'b0);
        blank_all = 1'b1;
        #1;
        chk("blank_now", digits, 16'hFFFF);
        blank_all = 1'b0;
        #1;
        chk("blank_release", digits, 16'h1234);
        step();
        blink_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            #1;
            chk($sformatf("blink_%0d", i), digits, ((i / 4) % 2) != 0 ? 16'hFFFF : 16'h1234);
            step();
        end
        blank_all = 1'b1;
        #1;
        chk("blank_over_blink", digits, 16'hFFFF);
        blink_en = 1'b0;
        #1;
        chk("blank_no_blink", digits, 16'hFFFF);
        blank_all = 1'b0;
        #1;
        chk("unblank", digits, 16'h1234);
        repeat (6) step();
        chk("steady", digits, 16'h1234);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
